// File: rtl/vnu_serial_accumulator.sv
// Serial VNU accumulate/emit stage: sums channel LLR plus DEGREE messages, then streams
// saturated sign-magnitude extrinsics. Optional out_post port under VNU_POSTERIOR_OUT_EN.
module vnu_serial_accumulator #(
  parameter int DATA_WIDTH = 5,
  parameter int DEGREE     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_msg,
  input  logic [DATA_WIDTH-1:0] in_llr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_msg,
  output logic                  out_hard,
`ifdef VNU_POSTERIOR_OUT_EN
  output logic [DATA_WIDTH-1:0] out_post,
`endif
  output logic                  out_last
);

  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(DEGREE + 1);
  localparam int CNT_WIDTH = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(DEGREE - 1);
  localparam logic [SUM_WIDTH-1:0] MAX_MAG =
    {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [0:0] {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [SUM_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]  buf_q [DEGREE];
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_msg_q;
  logic                   out_hard_q;
  logic                   out_last_q;
  logic [DATA_WIDTH-1:0]  out_post_q;

  logic [SUM_WIDTH-1:0]   acc_in_s;
  logic [SUM_WIDTH-1:0]   first_e_s;
  logic [CNT_WIDTH-1:0]   next_idx_s;
  logic [SUM_WIDTH-1:0]   next_e_s;

  function automatic logic [SUM_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(SUM_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Saturate to the symmetric message range; a zero result always has a clear sign bit.
  function automatic logic [DATA_WIDTH-1:0] to_sm(input logic [SUM_WIDTH-1:0] e);
    logic [SUM_WIDTH-1:0] mag;
    if (e[SUM_WIDTH-1]) begin
      mag = (~e) + SUM_WIDTH'(1'b1);
    end else begin
      mag = e;
    end
    if (mag > MAX_MAG) begin
      mag = MAX_MAG;
    end else begin
      mag = mag;
    end
    return {e[SUM_WIDTH-1], mag[DATA_WIDTH-2:0]};
  endfunction

  // Accumulator update for an accepted beat and extrinsic sums for the next emit beat.
  always_comb begin
    acc_in_s   = acc_q + sext(in_msg);
    next_idx_s = {CNT_WIDTH{1'b0}};
    if (cnt_q == {CNT_WIDTH{1'b0}}) begin
      acc_in_s = sext(in_llr) + sext(in_msg);
    end else begin
      acc_in_s = acc_q + sext(in_msg);
    end
    if (cnt_q == LAST_BEAT) begin
      next_idx_s = {CNT_WIDTH{1'b0}};
    end else begin
      next_idx_s = cnt_q + CNT_WIDTH'(1'b1);
    end
    first_e_s = acc_in_s - sext(buf_q[0]);
    next_e_s  = acc_q - sext(buf_q[next_idx_s]);
  end

  // Control FSM with registered outputs; buffer[0] is already captured when the last beat lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= {CNT_WIDTH{1'b0}};
      acc_q       <= {SUM_WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_msg_q   <= {DATA_WIDTH{1'b0}};
      out_hard_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_post_q  <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < DEGREE; i++) begin
        buf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            buf_q[cnt_q] <= in_msg;
            acc_q        <= acc_in_s;
            if (cnt_q == LAST_BEAT) begin
              state_q     <= EMIT;
              cnt_q       <= {CNT_WIDTH{1'b0}};
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_msg_q   <= to_sm(first_e_s);
              out_hard_q  <= acc_in_s[SUM_WIDTH-1];
              out_last_q  <= 1'b0;
              out_post_q  <= to_sm(acc_in_s);
            end else begin
              cnt_q <= cnt_q + CNT_WIDTH'(1'b1);
            end
          end else begin
            cnt_q <= cnt_q;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= ACCUM;
              cnt_q       <= {CNT_WIDTH{1'b0}};
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              cnt_q      <= next_idx_s;
              out_msg_q  <= to_sm(next_e_s);
              out_last_q <= (next_idx_s == LAST_BEAT);
            end
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q     <= ACCUM;
          cnt_q       <= {CNT_WIDTH{1'b0}};
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_msg   = out_msg_q;
  assign out_hard  = out_hard_q;
  assign out_last  = out_last_q;
`ifdef VNU_POSTERIOR_OUT_EN
  assign out_post  = out_post_q;
`endif

endmodule

// File: tb/tb_vnu_serial_accumulator.sv
// Scoreboard bench for vnu_serial_accumulator (DATA_WIDTH=5, DEGREE=3), directed vectors.
module tb_vnu_serial_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_msg = 5'd0;
  logic [4:0] in_llr = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_msg;
  logic       out_hard;
  logic       out_last;
  logic [4:0] out_post;

  typedef struct packed {
    logic [4:0] msg;
    logic       hard;
    logic       last;
    logic [4:0] post;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   after_last = 1'b0;

  vnu_serial_accumulator #(.DATA_WIDTH(5), .DEGREE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .in_llr    (in_llr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .out_hard  (out_hard),
`ifdef VNU_POSTERIOR_OUT_EN
    .out_post  (out_post),
`endif
    .out_last  (out_last)
  );

`ifndef VNU_POSTERIOR_OUT_EN
  assign out_post = 5'd0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (after_last) begin
      check("idle_after_last", {30'd0, in_ready, out_valid}, 32'd2);
      after_last = 1'b0;
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_msg", {27'd0, out_msg}, {27'd0, e.msg});
        check("out_hard", {31'd0, out_hard}, {31'd0, e.hard});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef VNU_POSTERIOR_OUT_EN
        check("out_post", {27'd0, out_post}, {27'd0, e.post});
`endif
        if (e.last) after_last = 1'b1;
      end
    end
  end

  task automatic expect_node(input logic [4:0] m0, input logic [4:0] m1, input logic [4:0] m2,
                             input logic hard, input logic [4:0] post);
    exp_q.push_back({m0, hard, 1'b0, post});
    exp_q.push_back({m1, hard, 1'b0, post});
    exp_q.push_back({m2, hard, 1'b1, post});
  endtask

  // Drives three beats; the accept of each beat is at the following posedge
  task automatic send_node(input logic [4:0] llr, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] c);
    logic [4:0] msgs [3];
    msgs[0] = a; msgs[1] = b; msgs[2] = c;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_msg   = msgs[i];
      in_llr   = (i == 0) ? llr : 5'd0;
      check("in_ready_accum", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("in_ready_emit", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (!(in_ready && !out_valid && exp_q.size() == 0) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("burst_timeout", {31'd0, (cyc >= 50) ? 1'b1 : 1'b0}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] held;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {20'd0, out_valid, out_msg, out_hard, out_last, out_post}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: total 8
    expect_node(5'b00110, 5'b01001, 5'b00100, 1'b0, 5'b01000);
    send_node(5'd3, 5'd2, 5'h1f, 5'd4);
    wait_idle();
    // 2: total -10
    expect_node(5'b10111, 5'b10111, 5'b11011, 1'b1, 5'b11010);
    send_node(5'h1b, 5'h1d, 5'h1d, 5'd1);
    wait_idle();
    // 3: saturation, total 60
    expect_node(5'b01111, 5'b01111, 5'b01111, 1'b0, 5'b01111);
    send_node(5'd15, 5'd15, 5'd15, 5'd15);
    wait_idle();
    // 4: zero handling
    expect_node(5'b10010, 5'b00010, 5'b00000, 1'b0, 5'b00000);
    send_node(5'd0, 5'd2, 5'h1e, 5'd0);
    wait_idle();

    // 5: backpressure at beat 1 with case 2 data, in_valid pulses must be ignored
    out_ready = 1'b0;
    expect_node(5'b10111, 5'b10111, 5'b11011, 1'b1, 5'b11010);
    send_node(5'h1b, 5'h1d, 5'h1d, 5'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    held = out_msg;
    check("bp_beat1_msg", {27'd0, held}, {27'd0, 5'b10111});
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_msg   = 5'd7;
      in_llr   = 5'd7;
      @(posedge clk); #1;
      check("bp_hold", {24'd0, out_valid, in_ready, out_last, out_msg}, {24'd0, 3'b100, held});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    expect_node(5'b10010, 5'b00010, 5'b00000, 1'b0, 5'b00000);
    send_node(5'd0, 5'd2, 5'h1e, 5'd0);
    wait_idle();

    // 6: reset while beat 1 is presented
    out_ready = 1'b0;
    expect_node(5'b00110, 5'b01001, 5'b00100, 1'b0, 5'b01000);
    send_node(5'd3, 5'd2, 5'h1f, 5'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_outs", {20'd0, out_valid, out_msg, out_hard, out_last, out_post}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_node(5'b00110, 5'b01001, 5'b00100, 1'b0, 5'b01000);
    send_node(5'd3, 5'd2, 5'h1f, 5'd4);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
